sd_spi_responder: RTL
=====================

Name: sd_spi_responder

Overview:
- Synchronous SD-card SPI-mode responder: the card side of the byte-oriented SPI master that drives spi_clk at clk/2 for the Mega Flash ROM SCC+ SD cart.
- Decodes 6-byte SD commands and returns R1/R3/R7 responses.
- Serves single-block reads (CMD17) from a 512-byte internal buffer, which the host fills on request.
- Used as a card model in simulation and as a disk-image-backed card in the core.

Parameters:
- NCR_BYTES, 1, count of 0xFF fill bytes between the command's last byte and the response (1..8).
- OCR_READY, 32'hC0FF8000, OCR returned by CMD58 after init (power-up done, CCS=1, block addressing).

Ports:
- clk  in  1  system clock; same clock as the SPI master.
- reset  in  1  asynchronous, active-high.
- spi_clk  in  1  SCK from master, idle low, synchronous to clk.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  master data out.
- spi_miso  out  1  responder data out; tx_sr[7] while selected, else 1.
- sd_rd  out  1  block read request; level signal, held until sd_ack.
- sd_lba  out  32  block address of the request; valid while sd_rd.
- sd_ack  in  1  one-cycle pulse: buffer is filled.
- buf_we  in  1  host write strobe into the block buffer.
- buf_addr  in  9  buffer byte address.
- buf_din  in  8  buffer write data.
- card_idle  out  1  card is in idle state (R1 bit 0).

Behaviour:
- Reset values: spi_miso=1, sd_rd=0, sd_lba=0, card_idle=1, tx_sr=FF, state=CMD_WAIT, bit count=0, app_cmd=0.
- Edge detect: sclk_q is spi_clk registered. A rising edge is spi_clk=1 & sclk_q=0.
- On each rising edge with cs_n=0:
  - rx_sr <= {rx_sr[6:0], mosi}.
  - tx_sr <= {tx_sr[6:0], 1}.
  - bit count +1.
- The master samples miso at the same clk edge, so it receives the pre-shift tx_sr[7].
- Byte boundary, i.e. the 8th rising edge:
  - The completed byte is {rx_sr[6:0], mosi}.
  - The bit count wraps to 0.
  - tx_sr loads the next outgoing byte from the state machine, not the shifted value.
- Deselect (cs_n=1): bit count=0, tx_sr=FF, state returns to CMD_WAIT. A pending sd_rd stays asserted until sd_ack; the data phase is abandoned.
- Byte-level FSM:
  - CMD_WAIT: a byte with [7:6]=01 stores cmd index [5:0] and goes to ARG. Any other byte is ignored; output FF.
  - ARG: collects 4 argument bytes MSB first, then 1 CRC byte (value ignored), then goes to NCR. Output FF.
  - NCR: sends NCR_BYTES of FF, then goes to RESP. The command is decoded at entry.
  - RESP: sends the response bytes. Next state is CMD_WAIT, or READ_WAIT for an accepted CMD17.
  - READ_WAIT: outputs FF until the sd_ack pulse has been seen, then goes to TOKEN.
  - TOKEN: sends FE, then goes to DATA.
  - DATA: sends buf[0..511] in order; a 9-bit pointer; the wrap from 511 goes to CRC.
  - CRC: sends FF, FF, then goes to CMD_WAIT.
- R1 = {5'b0, illegal, 1'b0, card_idle}. illegal = 0x04 position.
- Command decode (app_cmd selects the ACMD column):
  - CMD0: card_idle<=1, app_cmd<=0. Response R1=01.
  - CMD8: R7 = R1, 00, 00, {4'h0, arg[11:8]}, arg[7:0].
  - CMD55: app_cmd<=1. Response R1.
  - ACMD41: card_idle<=0. Response R1 using the new idle value (00).
  - CMD58: R3 = R1, then the OCR MSB first. OCR is OCR_READY, or OCR_READY & 7FFFFFFF while card_idle.
  - CMD16: R1 only; the argument is ignored.
  - CMD17 with card_idle=0: R1=00; at the end of RESP, sd_lba<=arg and sd_rd<=1.
  - CMD17 with card_idle=1: R1=05; no data phase.
  - Any other command: R1 = 04 | card_idle.
- app_cmd clears after any command other than CMD55.
- Handshake: sd_rd drops on the cycle after sd_ack. An sd_ack arriving while sd_rd=0 is ignored.
- Buffer: 512x8, written by the host at any time, read by the FSM. A write during the DATA phase is not protected.
- Reset mid-transfer: all state returns to its reset value immediately; a pending sd_rd is dropped.

Test Plan:
- CMD0 (40 00 00 00 00 95), then clock FF bytes -> NCR_BYTES x FF, then 01; card_idle=1.
- CMD8 arg 000001AA, then clock FF bytes -> 01 00 00 01 AA.
- CMD55 then ACMD41 (69 40 00 00 00 xx) -> 01 then 00; card_idle=0; CMD58 then returns 00 C0 FF 80 00.
- After init, CMD17 arg 00000123 -> R1 00, sd_rd=1 with sd_lba=123. Host fills buf[i]=i[7:0] and pulses sd_ack. Clocked bytes: FF during wait, FE, 00 01 .. FF 00 .. FF, then FF FF. sd_rd drops one cycle after ack.
- CMD17 before init -> 05, no sd_rd. Unknown CMD5 -> 05. Garbage byte 3C in CMD_WAIT -> ignored, miso stays 1.
- Raise cs_n mid-DATA, then reassert and send CMD0 -> immediately 01 after NCR. Assert reset during READ_WAIT -> sd_rd=0, card_idle=1, spi_miso=1.

Source files
------------

// File: rtl/sd_spi_responder.sv
// sd_spi_responder
// Card side of an SD card in SPI mode. Decodes 6-byte commands and answers
// with R1/R3/R7 responses. Single-block reads (CMD17) are served from a
// 512-byte buffer that the host fills when sd_rd is raised.
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   spi_clk            SCK from the master (idle low, synchronous to clk)
//   spi_cs_n           chip select, active low
//   spi_mosi           master data out
//   spi_miso           responder data out (1 while deselected)
//   sd_rd, sd_lba      block read request (level) and its block address
//   sd_ack             one-cycle pulse: the buffer holds the requested block
//   buf_we/addr/din    host write port into the block buffer
//   card_idle          card is in idle state (R1 bit 0)
module sd_spi_responder #(
  parameter int          NCR_BYTES = 1,
  parameter logic [31:0] OCR_READY = 32'hC0FF8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        sd_rd,
  output logic [31:0] sd_lba,
  input  logic        sd_ack,
  input  logic        buf_we,
  input  logic [8:0]  buf_addr,
  input  logic [7:0]  buf_din,
  output logic        card_idle
);

  typedef enum logic [2:0] {
    CMD_WAIT, ARG, NCR, RESP, READ_WAIT, TOKEN, DATA, CRC
  } state_t;

  localparam logic [3:0] NCR_LAST = 4'(NCR_BYTES);

  state_t      state, state_next;
  logic        sclk_q;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  tx_sr;
  logic [7:0]  tx_next;
  logic [7:0]  rx_byte;
  logic        rise;
  logic        boundary;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic [2:0]  arg_cnt;
  logic [3:0]  ncr_cnt;
  logic [39:0] resp_sr;
  logic [2:0]  resp_left;
  logic        read_go;
  logic        app_cmd;
  logic        ack_seen;
  logic [8:0]  ptr;
  logic        crc_cnt;
  logic [7:0]  mem [0:511];

  logic        dec_idle;
  logic        dec_app;
  logic        dec_read;
  logic [2:0]  dec_len;
  logic [7:0]  dec_r1;
  logic [31:0] dec_tail;

  assign rise     = spi_clk & ~sclk_q;
  assign boundary = rise & ~spi_cs_n & (bit_cnt == 3'd7);
  assign rx_byte  = {rx_sr, spi_mosi};
  assign spi_miso = spi_cs_n ? 1'b1 : tx_sr[7];

  // Host write port; the FSM reads asynchronously at ptr.
  always_ff @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_din;
  end

  // Command decode, evaluated while the CRC byte completes. The response is
  // left-aligned in 40 bits; R1 reflects the idle value after the command.
  always_comb begin
    dec_idle = card_idle;
    dec_app  = 1'b0;
    dec_read = 1'b0;
    dec_len  = 3'd1;
    dec_r1   = {7'b0, card_idle};
    dec_tail = 32'h0;
    case (cmd)
      6'd0: begin
        dec_idle = 1'b1;
        dec_r1   = 8'h01;
      end
      6'd8: begin
        dec_len  = 3'd5;
        dec_tail = {16'h0, 4'h0, arg[11:8], arg[7:0]};
      end
      6'd16: begin
        dec_r1 = {7'b0, card_idle};
      end
      6'd17: begin
        if (card_idle) begin
          dec_r1 = 8'h05;
        end else begin
          dec_r1   = 8'h00;
          dec_read = 1'b1;
        end
      end
      6'd41: begin
        if (app_cmd) begin
          dec_idle = 1'b0;
          dec_r1   = 8'h00;
        end else begin
          dec_r1 = {5'b0, 1'b1, 1'b0, card_idle};
        end
      end
      6'd55: begin
        dec_app = 1'b1;
      end
      6'd58: begin
        dec_len  = 3'd5;
        dec_tail = card_idle ? (OCR_READY & 32'h7FFFFFFF) : OCR_READY;
      end
      default: begin
        dec_r1 = {5'b0, 1'b1, 1'b0, card_idle};
      end
    endcase
  end

  // Byte-level next state and the byte to load into tx_sr at the boundary.
  // The state names what is being shifted out during the current byte.
  always_comb begin
    state_next = state;
    tx_next    = 8'hFF;
    if (spi_cs_n) begin
      state_next = CMD_WAIT;
    end else if (boundary) begin
      case (state)
        CMD_WAIT:  if (rx_byte[7:6] == 2'b01) state_next = ARG;
        ARG:       if (arg_cnt == 3'd4) state_next = NCR;
        NCR: begin
          if (ncr_cnt == NCR_LAST) begin
            state_next = RESP;
            tx_next    = resp_sr[39:32];
          end
        end
        RESP: begin
          if (resp_left == 3'd0) state_next = read_go ? READ_WAIT : CMD_WAIT;
          else tx_next = resp_sr[39:32];
        end
        READ_WAIT: begin
          if (ack_seen) begin
            state_next = TOKEN;
            tx_next    = 8'hFE;
          end
        end
        TOKEN: begin
          state_next = DATA;
          tx_next    = mem[ptr];
        end
        DATA: begin
          if (ptr == 9'd0) state_next = CRC;
          else tx_next = mem[ptr];
        end
        CRC:       if (crc_cnt) state_next = CMD_WAIT;
        default:   state_next = CMD_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CMD_WAIT;
    else state <= state_next;
  end

  // Bit shifting, byte counters, handshake and the per-state datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q    <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_sr     <= 7'h0;
      tx_sr     <= 8'hFF;
      cmd       <= 6'd0;
      arg       <= 32'h0;
      arg_cnt   <= 3'd0;
      ncr_cnt   <= 4'd0;
      resp_sr   <= 40'hFF_FFFF_FFFF;
      resp_left <= 3'd0;
      read_go   <= 1'b0;
      app_cmd   <= 1'b0;
      ack_seen  <= 1'b0;
      ptr       <= 9'd0;
      crc_cnt   <= 1'b0;
      sd_rd     <= 1'b0;
      sd_lba    <= 32'h0;
      card_idle <= 1'b1;
    end else begin
      sclk_q <= spi_clk;
      if (sd_rd && sd_ack) begin
        sd_rd    <= 1'b0;
        ack_seen <= 1'b1;
      end
      if (spi_cs_n) begin
        bit_cnt <= 3'd0;
        tx_sr   <= 8'hFF;
      end else if (rise) begin
        rx_sr <= rx_byte[6:0];
        if (bit_cnt == 3'd7) begin
          bit_cnt <= 3'd0;
          tx_sr   <= tx_next;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          tx_sr   <= {tx_sr[6:0], 1'b1};
        end
      end
      if (boundary) begin
        case (state)
          CMD_WAIT: begin
            if (rx_byte[7:6] == 2'b01) begin
              cmd     <= rx_byte[5:0];
              arg_cnt <= 3'd0;
            end
          end
          ARG: begin
            if (arg_cnt == 3'd4) begin
              ncr_cnt   <= 4'd1;
              resp_sr   <= {dec_r1, dec_tail};
              resp_left <= dec_len;
              card_idle <= dec_idle;
              app_cmd   <= dec_app;
              read_go   <= dec_read;
            end else begin
              arg     <= {arg[23:0], rx_byte};
              arg_cnt <= arg_cnt + 3'd1;
            end
          end
          NCR: begin
            if (ncr_cnt == NCR_LAST) begin
              resp_sr   <= {resp_sr[31:0], 8'hFF};
              resp_left <= resp_left - 3'd1;
            end else begin
              ncr_cnt <= ncr_cnt + 4'd1;
            end
          end
          RESP: begin
            if (resp_left == 3'd0) begin
              if (read_go) begin
                sd_rd    <= 1'b1;
                sd_lba   <= arg;
                ack_seen <= 1'b0;
              end
            end else begin
              resp_sr   <= {resp_sr[31:0], 8'hFF};
              resp_left <= resp_left - 3'd1;
            end
          end
          READ_WAIT: begin
            ptr     <= 9'd0;
            crc_cnt <= 1'b0;
          end
          TOKEN:   ptr <= 9'd1;
          DATA:    ptr <= ptr + 9'd1;
          CRC:     crc_cnt <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
